// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel counters, syncs, active flag, line/frame strobes
module vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter int   CLK_DIV     = 1,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        in_clk,
    input  logic        sys_reset_n,
    output logic [9:0]  x_out,
    output logic [9:0]  y_out,
    output logic        pix_en,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be in 1..8");
        end
    endgenerate

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
    // 11-bit bounds so a region ending exactly at 1024 does not alias to 0
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        running;
    logic [2:0]  div_cnt;
    logic [2:0]  div_n;
    logic [9:0]  h_n;
    logic [9:0]  v_n;
    logic [15:0] fc_n;
    logic        pe_n;
    logic [10:0] hx;
    logic [10:0] vx;
    logic        active_n;
    logic        hsync_n;
    logic        vsync_n;
    logic        line_n;
    logic        frame_n;

    // x_out/y_out are the counters themselves; running marks that (0,0) has been shown
    always_comb begin
        h_n   = x_out;
        v_n   = y_out;
        div_n = div_cnt;
        fc_n  = frame_cnt;
        pe_n  = 1'b0;
        if (!running) begin
            h_n   = '0;
            v_n   = '0;
            div_n = '0;
            pe_n  = 1'b1;
        end else if (div_cnt == DIV_LAST) begin
            div_n = '0;
            pe_n  = 1'b1;
            if (x_out == H_LAST) begin
                h_n = '0;
                if (y_out == V_LAST) begin
                    v_n  = '0;
                    fc_n = frame_cnt + 16'd1;
                end else begin
                    v_n = y_out + 10'd1;
                end
            end else begin
                h_n = x_out + 10'd1;
            end
        end else begin
            div_n = div_cnt + 3'd1;
        end
    end

    always_comb begin
        hx       = {1'b0, h_n};
        vx       = {1'b0, v_n};
        active_n = (hx < H_ACT_END) && (vx < V_ACT_END);
        hsync_n  = ((hx >= HS_BEG) && (hx < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_n  = ((vx >= VS_BEG) && (vx < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        line_n   = pe_n && (h_n == 10'd0);
        frame_n  = line_n && (v_n == 10'd0);
    end

    always_ff @(posedge in_clk) begin
        if (!sys_reset_n) begin
            running     <= 1'b0;
            div_cnt     <= '0;
            x_out       <= '0;
            y_out       <= '0;
            frame_cnt   <= '0;
            pix_en      <= 1'b0;
            active      <= 1'b0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= 1'b1;
            div_cnt     <= div_n;
            x_out       <= h_n;
            y_out       <= v_n;
            frame_cnt   <= fc_n;
            pix_en      <= pe_n;
            active      <= active_n;
            hsync       <= hsync_n;
            vsync       <= vsync_n;
            line_start  <= line_n;
            frame_start <= frame_n;
        end
    end

endmodule
